mips32_prog_loader: RTL and testbench
=====================================

Name: mips32_prog_loader

Overview:
- Sits directly upstream of pipe_MIPS32.
- Accepts a stream of 32-bit instruction and data words over a valid/ready port and writes them into the CPU memory starting at BASE_ADDR.
- Then releases the CPU (cpu_run) and watches HALTED.
- Reports completion or timeout together with the executed cycle count, so benches and top-level glue need no force-based preload.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- BASE_ADDR, 0, first address written.
- MAX_CYCLES, 1000, run-phase cycle limit before timeout.

Ports:
- clk1  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load beat valid.
- load_ready  output  1  loader accepts a beat.
- load_data  input  32  word to store.
- load_last  input  1  marks the final beat of the program.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  32  memory write data.
- cpu_run  output  1  high releases the CPU from hold.
- halted  input  1  CPU HALTED flag.
- clear  input  1  one-cycle pulse returns the loader from DONE/TIMEOUT to IDLE.
- done  output  1  CPU halted normally.
- timeout  output  1  MAX_CYCLES elapsed without halt.
- overflow  output  1  address space exhausted before load_last.
- cycle_count  output  32  cycles spent in RUN.

Behaviour:
- Reset (async, rst_n low): state=IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_run=0, done=0, timeout=0, overflow=0, cycle_count=0.
- Reset asserted mid-load or mid-run aborts immediately. cpu_run drops asynchronously. No partial-state recovery.
- A beat is accepted when load_valid && load_ready on a rising clk1 edge.
- load_ready = 1 in IDLE and LOAD only; 0 elsewhere.
- Write path is registered. The cycle after an accepted beat: mem_we=1, mem_addr=write pointer, mem_wdata=load_data. Then the pointer increments.
- With no accepted beat, mem_we=0 and mem_addr/mem_wdata hold.
- States:
  - IDLE: pointer=BASE_ADDR. First accepted beat goes to LOAD, or to DRAIN if load_last is set. The first beat clears done, timeout, overflow and cycle_count.
  - LOAD: each accepted beat writes at the pointer. A beat with load_last goes to DRAIN.
  - LOAD, overflow: an accepted beat at pointer = 2^ADDR_W-1 without load_last still writes. It then sets overflow=1 and goes to DRAIN. The pointer never wraps.
  - DRAIN: one cycle so the final write completes before the CPU fetches. Goes to RUN.
  - RUN: cpu_run=1; cycle_count increments every cycle, including the entry cycle.
    - halted=1 goes to DONE.
    - Otherwise, cycle_count reaching MAX_CYCLES goes to TIMEOUT.
    - halted and the limit in the same cycle: DONE wins.
  - DONE: cpu_run=0, done=1, cycle_count frozen.
  - TIMEOUT: cpu_run=0, timeout=1, cycle_count frozen at MAX_CYCLES.
  - DONE/TIMEOUT: clear goes to IDLE. Flags and count stay visible until the next first beat. clear in any other state is ignored.
- Beats presented while load_ready=0 are not accepted; the source must hold them.
- halted outside RUN is ignored.

Test Plan:
- 4-beat load (0x01, 0x02, 0x03, 0x04, last on beat 4), CPU halts 20 cycles after cpu_run rises -> mem writes to addresses 0..3 in order, one cycle after each beat; DRAIN one cycle; done=1, cycle_count=21, cpu_run=0.
- Gapped load_valid (beats every third cycle) -> identical memory contents and addresses; mem_we pulses only after accepted beats.
- halted never asserted, MAX_CYCLES=1000 -> timeout=1, done=0, cycle_count=1000, cpu_run low the following cycle.
- ADDR_W=2, 5 beats without last -> writes to addresses 0..3; overflow=1 after the 4th beat; load_ready=0 for the 5th; RUN entered.
- halted rising the same cycle cycle_count reaches MAX_CYCLES -> done=1, timeout=0.
- rst_n pulled low during RUN at cycle 7 -> cpu_run=0 immediately, all outputs at reset values. A new 1-beat load afterwards completes normally, then clear returns to IDLE.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Streams a program into CPU memory, releases the CPU, then reports halt or timeout with the run length.
// Memory write lags each accepted beat by one cycle; load_ready is low outside IDLE/LOAD and the source must hold.
module mips32_prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  input  logic              halted,
  input  logic              clear,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [31:0]       cycle_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP   = '1;
  localparam logic [31:0]       LIMIT = 32'(MAX_CYCLES);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              at_top;
  logic              limit_hit;
  logic              load_end;

  assign load_ready = (state == S_IDLE) || (state == S_LOAD);
  assign accept     = load_valid && load_ready;
  assign at_top     = (ptr == TOP);
  assign load_end   = load_last || at_top;
  assign limit_hit  = (cycle_count + 32'd1) >= LIMIT;

  // Derived from the state register so an async reset drops it without waiting for a clock.
  assign cpu_run = (state == S_RUN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) state_nx = load_end ? S_DRAIN : S_LOAD;
      end
      S_DRAIN: state_nx = S_RUN;
      S_RUN: begin
        if (halted)         state_nx = S_DONE;
        else if (limit_hit) state_nx = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: begin
        if (clear) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= BASE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= 32'd0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      state  <= state_nx;
      mem_we <= accept;

      if (accept) begin
        mem_addr  <= ptr;
        mem_wdata <= load_data;
        // Saturate at the top word instead of wrapping over the program start.
        if (!at_top) ptr <= ptr + ADDR_W'(1);
        if (state == S_IDLE) begin
          done        <= 1'b0;
          timeout     <= 1'b0;
          overflow    <= 1'b0;
          cycle_count <= 32'd0;
        end
        if (at_top && !load_last) overflow <= 1'b1;
      end

      if (state == S_RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (halted)         done    <= 1'b1;
        else if (limit_hit) timeout <= 1'b1;
      end

      // Flags and count remain visible in IDLE until the next program's first beat.
      if ((state == S_DONE || state == S_TIMEOUT) && clear) ptr <= BASE;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: random programs and halt times checked against a transaction-level model.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 2;
  localparam int BASE   = 0;
  localparam int MAXC   = 1000;
  localparam int CAP    = (1 << ADDR_W) - BASE;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [31:0]       load_data = 32'd0;
  logic              load_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              halted = 1'b0;
  logic              clear = 1'b0;
  logic              done;
  logic              timeout;
  logic              overflow;
  logic [31:0]       cycle_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [8];

  mips32_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_CYCLES(MAXC)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .halted(halted), .clear(clear),
    .done(done), .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents n beats with gap idle cycles between them and checks every resulting memory write.
  task automatic do_load(input int n, input int gap, input int last_idx);
    int exp_acc, i, idle, beat;
    bit pend, ovf_exp;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_data;
    exp_acc = (last_idx >= 0 && last_idx < CAP) ? last_idx + 1 : CAP;
    ovf_exp = !(last_idx >= 0 && last_idx < CAP);
    i = 0; idle = 0; pend = 0; beat = 0;
    exp_addr = '0; exp_data = '0;
    while (i < exp_acc || pend) begin
      @(negedge clk1);
      checks++;
      if (pend) begin
        if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data) begin
          errors++;
          $display("FAIL write beat %0d: we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                   beat, mem_we, mem_addr, mem_wdata, exp_addr, exp_data);
        end
        if (beat == 0) begin
          checks++;
          if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL flags_cleared: done=%b timeout=%b count=%0d, expected 0 0 0",
                     done, timeout, cycle_count);
          end
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_we: mem_we=%b without accepted beat, expected 0", mem_we);
      end
      pend = 0;
      if (i >= exp_acc) begin
        load_valid = 1'b0; load_last = 1'b0;
      end else if (idle > 0) begin
        idle--;
        load_valid = 1'b0; load_last = 1'b0; load_data = $urandom;
      end else begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready beat %0d: load_ready=%b, expected 1", i, load_ready);
        end
        load_valid = 1'b1; load_data = prog[i]; load_last = (i == last_idx);
        exp_addr = ADDR_W'(BASE + i); exp_data = prog[i];
        beat = i; pend = 1; i++; idle = gap;
      end
    end
    checks++;
    if (cpu_run !== 1'b0 || overflow !== ovf_exp) begin
      errors++;
      $display("FAIL drain: cpu_run=%b overflow=%b, expected 0 %b", cpu_run, overflow, ovf_exp);
    end
    if (ovf_exp && n > exp_acc) begin
      checks++;
      if (load_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_after_overflow: load_ready=%b, expected 0", load_ready);
      end
      load_valid = 1'b1; load_data = prog[exp_acc]; load_last = 1'b0;
      @(negedge clk1);
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rejected_beat: mem_we=%b, expected 0", mem_we);
      end
      load_valid = 1'b0;
    end else begin
      @(negedge clk1);
    end
    checks++;
    if (cpu_run !== 1'b1 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL run_entry: cpu_run=%b count=%0d, expected 1 0", cpu_run, cycle_count);
    end
  endtask

  // Called at the first negedge of RUN; halted rises k cycles later (k<0: never).
  task automatic do_run(input int k, input bit ovf_exp);
    int n, seen, exp_cnt;
    bit track_ok, exp_done;
    exp_done = (k >= 0) && (k + 1 <= MAXC);
    exp_cnt  = exp_done ? k + 1 : MAXC;
    n = 0; seen = 0; track_ok = 1;
    while (cpu_run === 1'b1 && n < MAXC + 5) begin
      if (cycle_count !== 32'(n)) track_ok = 0;
      if (n == k) halted = 1'b1;
      seen++; n++;
      @(negedge clk1);
    end
    halted = 1'b0;
    checks++;
    if (!track_ok || seen != exp_cnt) begin
      errors++;
      $display("FAIL run_length: cycles high=%0d tracking=%0d, expected %0d tracking=1", seen, track_ok, exp_cnt);
    end
    checks++;
    if (done !== exp_done || timeout !== !exp_done || cycle_count !== 32'(exp_cnt) || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL finish: done=%b timeout=%b count=%0d cpu_run=%b, expected %b %b %0d 0",
               done, timeout, cycle_count, cpu_run, exp_done, !exp_done, exp_cnt);
    end
    repeat (3) @(negedge clk1);
    checks++;
    if (cycle_count !== 32'(exp_cnt) || load_ready !== 1'b0 || overflow !== ovf_exp) begin
      errors++;
      $display("FAIL frozen: count=%0d ready=%b overflow=%b, expected %0d 0 %b",
               cycle_count, load_ready, overflow, exp_cnt, ovf_exp);
    end
    clear = 1'b1;
    @(negedge clk1);
    clear = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || done !== exp_done || timeout !== !exp_done || cycle_count !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL clear: ready=%b done=%b timeout=%b count=%0d, expected 1 %b %b %0d",
               load_ready, done, timeout, cycle_count, exp_done, !exp_done, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== ADDR_W'(BASE) || mem_wdata !== 32'd0 || cpu_run !== 1'b0 ||
        done !== 1'b0 || timeout !== 1'b0 || overflow !== 1'b0 || cycle_count !== 32'd0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: we=%b addr=%0d wdata=%h run=%b done=%b to=%b ovf=%b cnt=%0d rdy=%b, expected all 0, ready 1",
               mem_we, mem_addr, mem_wdata, cpu_run, done, timeout, overflow, cycle_count, load_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) prog[i] = 32'(i + 1);
    do_load(4, 0, 3);
    do_run(20, 1'b0);
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) prog[i] = 32'(i + 1);
    do_load(4, 2, 3);
    do_run(5, 1'b0);
  endtask

  task automatic test_timeout();
    prog[0] = $urandom; prog[1] = $urandom;
    do_load(2, 1, 1);
    do_run(-1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    do_load(5, 0, -1);
    do_run(3, 1'b1);
  endtask

  task automatic test_tie();
    prog[0] = $urandom;
    do_load(1, 0, 0);
    do_run(MAXC - 1, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    halted = 1'b1;
    clear  = 1'b1;
    repeat (2) @(negedge clk1);
    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    do_load(3, 1, 2);
    clear = 1'b0;
    do_run(0, 1'b0);
  endtask

  task automatic test_random();
    int n, last_idx, gap, k;
    bit ovf;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 6);
      last_idx = $urandom_range(0, n - 1);
      if (n > CAP && $urandom_range(0, 1) == 1) last_idx = -1;
      gap = $urandom_range(0, 2);
      k = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      ovf = !(last_idx >= 0 && last_idx < CAP);
      do_load(n, gap, last_idx);
      do_run(k, ovf);
    end
  endtask

  task automatic test_reset_run();
    prog[0] = $urandom; prog[1] = $urandom;
    do_load(2, 0, 1);
    for (int n = 0; n < 7; n++) @(negedge clk1);
    checks++;
    if (cpu_run !== 1'b1 || cycle_count !== 32'd7) begin
      errors++;
      $display("FAIL pre_reset: cpu_run=%b count=%0d, expected 1 7", cpu_run, cycle_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_run !== 1'b0 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(BASE) || mem_wdata !== 32'd0 ||
        done !== 1'b0 || timeout !== 1'b0 || overflow !== 1'b0 || cycle_count !== 32'd0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: run=%b we=%b addr=%0d wdata=%h done=%b to=%b ovf=%b cnt=%0d rdy=%b, expected reset values",
               cpu_run, mem_we, mem_addr, mem_wdata, done, timeout, overflow, cycle_count, load_ready);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    prog[0] = $urandom;
    do_load(1, 0, 0);
    do_run($urandom_range(0, 15), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_overflow();
    test_tie();
    test_ignored_inputs();
    test_random();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
